// File: rtl/sw_score_engine.sv
// Smith-Waterman local-alignment scoring core: one PE, one matrix cell per clock,
// query held in a column buffer while reference bases stream in one column at a time.
module sw_score_engine #(
   parameter int MAX_Q    = 16,
   parameter int SW       = 8,
   parameter int MATCH    = 2,
   parameter int MISMATCH = 1,
   parameter int GAP      = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [2*MAX_Q-1:0]           q_seq,
   input  logic [$clog2(MAX_Q+1)-1:0]   q_len,
   input  logic                         r_valid,
   input  logic [1:0]                   r_base,
   input  logic                         r_last,
   output logic                         r_ready,
   output logic                         busy,
   output logic                         done,
   output logic [SW-1:0]                max_score,
   output logic [$clog2(MAX_Q+1)-1:0]   max_i,
   output logic [15:0]                  max_j
);
   localparam int IW = $clog2(MAX_Q+1);
   localparam int QW = $clog2(MAX_Q);

   typedef enum logic [2:0] {IDLE, LOAD, WAIT_R, COMP, FIN} state_t;
   state_t r_state, w_next;

   logic [2*MAX_Q-1:0] r_q;
   logic [IW-1:0]      r_qlen, r_i, r_max_i;
   logic [SW-1:0]      r_col [MAX_Q];
   logic [SW-1:0]      r_diag, r_up, r_max_score;
   logic [1:0]         r_rbase;
   logic               r_lastf;
   logic [15:0]        r_j, r_max_j;

   logic [QW-1:0]      w_idx;
   logic [1:0]         w_qb;
   logic [SW-1:0]      w_col, w_dterm, w_left, w_upt, w_h1, w_h;
   logic [SW:0]        w_dsum;

   // Cell i lives at buffer index i-1; query base i-1 sits at bits [2(i-1)+1:2(i-1)].
   assign w_idx  = QW'(r_i - 1'b1);
   assign w_qb   = r_q[{w_idx, 1'b0} +: 2];
   assign w_col  = r_col[w_idx];
   assign w_dsum = {1'b0, r_diag} + (SW+1)'(MATCH);

   always_comb begin
      if (w_qb == r_rbase)
         w_dterm = w_dsum[SW] ? '1 : w_dsum[SW-1:0];
      else
         w_dterm = (r_diag >= SW'(MISMATCH)) ? r_diag - SW'(MISMATCH) : '0;
      w_left = (w_col >= SW'(GAP)) ? w_col - SW'(GAP) : '0;
      w_upt  = (r_up  >= SW'(GAP)) ? r_up  - SW'(GAP) : '0;
      w_h1   = (w_dterm > w_left) ? w_dterm : w_left;
      w_h    = (w_h1 > w_upt) ? w_h1 : w_upt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:   if (start) w_next = LOAD;
         LOAD:   w_next = WAIT_R;
         WAIT_R: if (r_valid) begin
                    if (r_qlen == '0) w_next = r_last ? FIN : WAIT_R;
                    else              w_next = COMP;
                 end
         COMP:   if (r_i == r_qlen) w_next = r_lastf ? FIN : WAIT_R;
         FIN:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      r_ready = (r_state == WAIT_R);
      busy    = (r_state != IDLE);
      done    = (r_state == FIN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q         <= '0;
         r_qlen      <= '0;
         r_i         <= '0;
         r_j         <= '0;
         r_diag      <= '0;
         r_up        <= '0;
         r_rbase     <= '0;
         r_lastf     <= 1'b0;
         r_max_score <= '0;
         r_max_i     <= '0;
         r_max_j     <= '0;
         for (int k = 0; k < MAX_Q; k++) r_col[k] <= '0;
      end else begin
         case (r_state)
            IDLE: if (start) begin
               r_q         <= q_seq;
               r_qlen      <= q_len;
               r_j         <= '0;
               r_max_score <= '0;
               r_max_i     <= '0;
               r_max_j     <= '0;
               for (int k = 0; k < MAX_Q; k++) r_col[k] <= '0;
            end
            WAIT_R: if (r_valid) begin
               r_rbase <= r_base;
               r_lastf <= r_last;
               r_j     <= r_j + 16'd1;
               r_i     <= IW'(1);
               r_diag  <= '0;
               r_up    <= '0;
            end
            COMP: begin
               r_diag       <= w_col;
               r_col[w_idx] <= w_h;
               r_up         <= w_h;
               r_i          <= r_i + 1'b1;
               // Strict compare keeps the first cell to reach a new best.
               if (w_h > r_max_score) begin
                  r_max_score <= w_h;
                  r_max_i     <= r_i;
                  r_max_j     <= r_j;
               end
            end
            default: ;
         endcase
      end
   end

   assign max_score = r_max_score;
   assign max_i     = r_max_i;
   assign max_j     = r_max_j;
endmodule

// File: tb/tb_sw_score_engine.sv
// Drives an 8-bit and a 3-bit score engine in lockstep and checks both against a
// plain integer Smith-Waterman model.
module tb_sw_score_engine;
   localparam int MQ = 16;

   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [2*MQ-1:0] q_seq = '0;
   logic [4:0]    q_len = '0;
   logic          r_valid = 1'b0, r_last = 1'b0;
   logic [1:0]    r_base = '0;

   logic          rdy8, busy8, done8, rdy3, busy3, done3;
   logic [7:0]    ms8;
   logic [2:0]    ms3;
   logic [4:0]    mi8, mi3;
   logic [15:0]   mj8, mj3;

   int n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   sw_score_engine dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .q_seq(q_seq), .q_len(q_len),
      .r_valid(r_valid), .r_base(r_base), .r_last(r_last), .r_ready(rdy8),
      .busy(busy8), .done(done8), .max_score(ms8), .max_i(mi8), .max_j(mj8));

   sw_score_engine #(.SW(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start), .q_seq(q_seq), .q_len(q_len),
      .r_valid(r_valid), .r_base(r_base), .r_last(r_last), .r_ready(rdy3),
      .busy(busy3), .done(done3), .max_score(ms3), .max_i(mi3), .max_j(mj3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int enc(input byte c);
      case (c)
         "A": return 0;
         "C": return 1;
         "G": return 2;
         default: return 3;
      endcase
   endfunction

   function automatic void mk(input string s, output logic [31:0] v, output int a[64], output int n);
      v = '0;
      n = s.len();
      for (int k = 0; k < 64; k++) a[k] = 0;
      for (int k = 0; k < n; k++) begin
         a[k] = enc(s[k]);
         if (k < 16) v[2*k +: 2] = 2'(a[k]);
      end
   endfunction

   // Full local-alignment recurrence over the whole matrix, column by column.
   function automatic void sw_model(input int sw, input logic [31:0] q, input int qlen,
                                    input int rb[64], input int nref,
                                    output int ms, output int mi, output int mj);
      int col[17];
      int hmax, diag, up, best, t, qb;
      hmax = (1 << sw) - 1;
      ms = 0; mi = 0; mj = 0;
      for (int k = 0; k < 17; k++) col[k] = 0;
      for (int j = 1; j <= nref; j++) begin
         diag = 0; up = 0;
         for (int i = 1; i <= qlen; i++) begin
            qb = int'(q[2*(i-1) +: 2]);
            t = (qb == rb[j-1]) ? diag + 2 : diag - 1;
            if (t > hmax) t = hmax;
            best = (t > 0) ? t : 0;
            if (col[i] - 1 > best) best = col[i] - 1;
            if (up - 1 > best) best = up - 1;
            diag = col[i];
            col[i] = best;
            up = best;
            if (best > ms) begin ms = best; mi = i; mj = j; end
         end
      end
   endfunction

   task automatic run_job(input string tag, input logic [31:0] q, input int qlen,
                          input int rb[64], input int nref, input int gap, input bit intr);
      int e8s, e8i, e8j, e3s, e3i, e3j, w, lat, dn;
      sw_model(8, q, qlen, rb, nref, e8s, e8i, e8j);
      sw_model(3, q, qlen, rb, nref, e3s, e3i, e3j);
      @(negedge clk);
      q_seq = q; q_len = 5'(qlen); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, " busy"}, busy8, 1);
      for (int k = 0; k < nref; k++) begin
         for (int g = 0; g < gap; g++) begin
            r_valid = 1'b0;
            if (intr && k == 1 && g == 0) begin
               start = 1'b1; q_seq = $urandom; q_len = 5'd1;
            end else start = 1'b0;
            @(negedge clk);
         end
         start = 1'b0;
         r_valid = 1'b1; r_base = 2'(rb[k]); r_last = (k == nref - 1);
         w = 0;
         while (!rdy8 && w < 100) begin @(negedge clk); w++; end
         if (gap == 0) chk({tag, " ready wait"}, w, (k == 0) ? 1 : qlen);
         chk({tag, " ready"}, {rdy8, rdy3}, 2'b11);
         @(negedge clk);
      end
      r_valid = 1'b0; r_last = 1'b0;
      lat = 1;
      while (!done8 && lat < 100) begin @(negedge clk); lat++; end
      chk({tag, " done latency"}, lat, qlen + 1);
      chk({tag, " done/busy"}, {done8, done3, busy8}, 3'b111);
      chk({tag, " score8"}, ms8, e8s);
      chk({tag, " i8"}, mi8, e8i);
      chk({tag, " j8"}, mj8, e8j);
      chk({tag, " score3"}, ms3, e3s);
      chk({tag, " i3"}, mi3, e3i);
      chk({tag, " j3"}, mj3, e3j);
      dn = 0;
      repeat (4) begin @(negedge clk); if (done8 || done3) dn++; end
      chk({tag, " extra done"}, dn, 0);
      chk({tag, " idle busy"}, busy8, 0);
      chk({tag, " score hold"}, ms8, e8s);
   endtask

   initial begin
      logic [31:0] qv;
      int ra[64], qa[64];
      int nr, nq, w;

      repeat (2) @(negedge clk);
      chk("reset ctl", {rdy8, busy8, done8}, 3'b000);
      chk("reset max", {ms8, mi8, mj8}, 0);
      rst_n = 1'b1;

      mk("ACGT", qv, qa, nq);   mk("ACGT", qv, ra, nr);  mk("ACGT", qv, qa, nq);
      run_job("c1", qv, nq, ra, nr, 0, 1'b0);
      chk("c1 const", {ms8, mi8, mj8}, {8'd8, 5'd4, 16'd4});
      mk("TTTT", qv, ra, nr);   mk("AAAA", qv, qa, nq);
      run_job("c2", qv, nq, ra, nr, 0, 1'b0);
      chk("c2 const", {ms8, mi8, mj8}, 0);
      mk("TACGTT", qv, ra, nr); mk("ACGT", qv, qa, nq);
      run_job("c3", qv, nq, ra, nr, 0, 1'b0);
      chk("c3 const", {ms8, mi8, mj8}, {8'd8, 5'd4, 16'd5});
      mk("AC", qv, ra, nr);
      run_job("c4a", '0, 0, ra, nr, 0, 1'b0);
      mk("AAAAA", qv, ra, nr);  mk("AAAAA", qv, qa, nq);
      run_job("c4b", qv, nq, ra, nr, 0, 1'b0);
      chk("c4b sat", {ms3, mi3, mj3}, {3'd7, 5'd4, 16'd4});
      mk("ACGT", qv, ra, nr);   mk("ACGT", qv, qa, nq);
      run_job("c5", qv, nq, ra, nr, 3, 1'b1);

      // Reset while the second column is being computed.
      @(negedge clk);
      q_seq = qv; q_len = 5'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         r_valid = 1'b1; r_base = 2'(ra[k]); r_last = 1'b0;
         w = 0;
         while (!rdy8 && w < 100) begin @(negedge clk); w++; end
         @(negedge clk);
      end
      r_valid = 1'b0;
      chk("c6 pre-reset score", ms8, 2);
      rst_n = 1'b0;
      #1;
      chk("c6 reset ctl", {rdy8, busy8, done8}, 3'b000);
      chk("c6 reset max", {ms8, mi8, mj8}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_job("c6 rerun", qv, 4, ra, nr, 0, 1'b0);

      for (int t = 0; t < 25; t++) begin
         int ql, nrr, gp;
         ql = $urandom_range(0, 16);
         nrr = $urandom_range(1, 20);
         gp = $urandom_range(0, 1);
         qv = $urandom;
         for (int k = 0; k < 64; k++) ra[k] = (k < nrr) ? int'($urandom_range(0, 3)) : 0;
         run_job($sformatf("rnd%0d", t), qv, ql, ra, nrr, gp, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
